// File: rtl/msk_gfmul_hpc1_pipe_if.sv
// Handshake and data bundle for the masked GF(2^W) multiplier.
// The master side drives operands, randomness and downstream ready; the slave is the multiplier.
// Optional flush signal appears when MSK_GFMUL_FLUSH_EN is defined.
interface msk_gfmul_hpc1_pipe_if #(
  parameter int D = 2,
  parameter int W = 2
);
  localparam int R = W * D * (D - 1) / 2 + W * W * D * (D - 1) / 2;

  logic [W*D-1:0] in_a;
  logic [W*D-1:0] in_b;
  logic           in_valid;
  logic           in_ready;
  logic [R-1:0]   rnd;
  logic           rnd_valid;
  logic [W*D-1:0] out_c;
  logic           out_valid;
  logic           out_ready;

`ifdef MSK_GFMUL_FLUSH_EN
  logic           flush;

  modport master (
    output in_a, in_b, in_valid, rnd, rnd_valid, out_ready, flush,
    input  in_ready, out_c, out_valid
  );

  modport slave (
    input  in_a, in_b, in_valid, rnd, rnd_valid, out_ready, flush,
    output in_ready, out_c, out_valid
  );
`else
  modport master (
    output in_a, in_b, in_valid, rnd, rnd_valid, out_ready,
    input  in_ready, out_c, out_valid
  );

  modport slave (
    input  in_a, in_b, in_valid, rnd, rnd_valid, out_ready,
    output in_ready, out_c, out_valid
  );
`endif
endinterface

// File: rtl/msk_gfmul_hpc1_pipe.sv
// Masked GF(2^W) multiplier (HPC1): SNI refresh of b, DOM product of every bit pair,
// per-share polynomial reduction. Two register stages, valid/ready flow control,
// stalls whenever fresh randomness is absent.
// Optional feature: define MSK_GFMUL_FLUSH_EN to add a flush input that empties the pipe.
// Share layout: bit i, share j lives at index i*D+j.
module msk_gfmul_hpc1_pipe #(
  parameter int             D    = 2,
  parameter int             W    = 2,
  parameter logic [W-1:0]   POLY = 2'b11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  msk_gfmul_hpc1_pipe_if.slave  bus
);

  localparam int NP    = D * (D - 1) / 2;
  localparam int R_REF = W * NP;
  localparam int NT    = W * W * D * D;
  localparam int PW    = 2 * W - 1;

  logic           en;
  logic [W*D-1:0] b_ref;
  logic [W*D-1:0] a_p1_d, a_p1_q;
  logic [W*D-1:0] b_p1_d, b_p1_q;
  logic           vld_p1_d, vld_p1_q;
  logic [NT-1:0]  term_p2_d, term_p2_q;
  logic           vld_p2_d, vld_p2_q;
  logic [PW-1:0]  prod_s;
  logic [W-1:0]   red_s;
  logic [W*D-1:0] c_comb;

  // Index of unordered share pair (j,k), j<k, in a block of NP random bits.
  function automatic int pair_idx(input int j, input int k);
    return j * D - (j * (j + 1)) / 2 + (k - j - 1);
  endfunction

  // Fold coefficients of degree >= W back using x^W = POLY.
  function automatic logic [W-1:0] gf_reduce(input logic [PW-1:0] p);
    logic [PW-1:0] acc;
    acc = p;
    for (int deg = PW - 1; deg >= W; deg--) begin
      if (acc[deg]) begin
        acc[deg]           = 1'b0;
        acc[deg-W +: W]    = acc[deg-W +: W] ^ POLY;
      end
    end
    return acc[W-1:0];
  endfunction

  // Advance only with fresh randomness and room downstream; flush blocks acceptance.
  always_comb begin
    en = bus.rnd_valid & (~vld_p2_q | bus.out_ready);
`ifdef MSK_GFMUL_FLUSH_EN
    en = en & ~bus.flush;
`endif
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = vld_p2_q;
  assign bus.out_c     = c_comb;

  // Pairwise refresh of b: each random bit lands on both shares of its pair.
  always_comb begin
    b_ref = bus.in_b;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < D; j++) begin
        for (int k = j + 1; k < D; k++) begin
          b_ref[i*D+j] = b_ref[i*D+j] ^ bus.rnd[i*NP + pair_idx(j, k)];
          b_ref[i*D+k] = b_ref[i*D+k] ^ bus.rnd[i*NP + pair_idx(j, k)];
        end
      end
    end
  end

  // ---- stage 1: capture a (alignment) and refreshed b ----
  always_comb begin
    a_p1_d   = a_p1_q;
    b_p1_d   = b_p1_q;
    vld_p1_d = vld_p1_q;
    if (en) begin
      a_p1_d   = bus.in_a;
      b_p1_d   = b_ref;
      vld_p1_d = bus.in_valid;
    end
`ifdef MSK_GFMUL_FLUSH_EN
    if (bus.flush) vld_p1_d = 1'b0;
`endif
  end

  // ---- stage 2: DOM partial products, each term kept in its own flop ----
  always_comb begin
    term_p2_d = term_p2_q;
    vld_p2_d  = vld_p2_q;
    if (en) begin
      vld_p2_d = vld_p1_q;
      for (int i = 0; i < W; i++) begin
        for (int k = 0; k < W; k++) begin
          for (int j = 0; j < D; j++) begin
            for (int l = 0; l < D; l++) begin
              if (j == l) begin
                term_p2_d[((i*W+k)*D+j)*D+l] = a_p1_q[i*D+j] & b_p1_q[k*D+l];
              end else begin
                term_p2_d[((i*W+k)*D+j)*D+l] = (a_p1_q[i*D+j] & b_p1_q[k*D+l])
                  ^ bus.rnd[R_REF + (i*W+k)*NP
                            + pair_idx((j < l) ? j : l, (j < l) ? l : j)];
              end
            end
          end
        end
      end
    end
`ifdef MSK_GFMUL_FLUSH_EN
    if (bus.flush) vld_p2_d = 1'b0;
`endif
  end

  // Data registers: no reset, they only move when the pipe advances.
  always_ff @(posedge clk) begin
    a_p1_q    <= a_p1_d;
    b_p1_q    <= b_p1_d;
    term_p2_q <= term_p2_d;
  end

  // Valid bits: the only reset state in the pipe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  // ---- output: per-share compression into 2W-1 coefficients, then reduction ----
  always_comb begin
    c_comb = '0;
    prod_s = '0;
    red_s  = '0;
    for (int j = 0; j < D; j++) begin
      prod_s = '0;
      for (int i = 0; i < W; i++) begin
        for (int k = 0; k < W; k++) begin
          for (int l = 0; l < D; l++) begin
            prod_s[i+k] = prod_s[i+k] ^ term_p2_q[((i*W+k)*D+j)*D+l];
          end
        end
      end
      red_s = gf_reduce(prod_s);
      for (int i = 0; i < W; i++) begin
        c_comb[i*D+j] = red_s[i];
      end
    end
  end

endmodule

// File: tb/tb_msk_gfmul_hpc1_pipe.sv
// Scoreboard bench for msk_gfmul_hpc1_pipe: three instances (GF(4) D=2, GF(16) D=2,
// GF(256) D=3). Stimulus pushes expected unmasked products; monitors pop and compare.
module tb_msk_gfmul_hpc1_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  msk_gfmul_hpc1_pipe_if #(.D(2), .W(2)) if0 ();
  msk_gfmul_hpc1_pipe_if #(.D(2), .W(4)) if1 ();
  msk_gfmul_hpc1_pipe_if #(.D(3), .W(8)) if2 ();

  msk_gfmul_hpc1_pipe #(.D(2), .W(2), .POLY(2'b11))   u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  msk_gfmul_hpc1_pipe #(.D(2), .W(4), .POLY(4'h3))    u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  msk_gfmul_hpc1_pipe #(.D(3), .W(8), .POLY(8'h1B))   u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  int total = 0;
  int bad   = 0;
  int stalls0 = 0;
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  logic [7:0] exp2[$];

  logic fire0;
  always_comb begin
`ifdef MSK_GFMUL_FLUSH_EN
    fire0 = if0.out_ready & if0.rnd_valid & ~if0.flush;
`else
    fire0 = if0.out_ready & if0.rnd_valid;
`endif
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Split value v (w bits) into d shares with random masks; bit i share j at i*d+j.
  function automatic logic [23:0] mask_val(input logic [7:0] v, input int w, input int d);
    logic [23:0] s;
    logic acc;
    s = '0;
    for (int i = 0; i < w; i++) begin
      acc = v[i];
      for (int j = 0; j < d - 1; j++) begin
        s[i*d+j] = 1'($urandom_range(0, 1));
        acc = acc ^ s[i*d+j];
      end
      s[i*d+d-1] = acc;
    end
    return s;
  endfunction

  function automatic logic [7:0] unmask(input logic [23:0] s, input int w, input int d);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < w; i++)
      for (int j = 0; j < d; j++)
        r[i] = r[i] ^ s[i*d+j];
    return r;
  endfunction

  // GF(4) with x^2 = x+1: elements 0,1,x=2,x+1=3.
  function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
    if (a == 2'd0 || b == 2'd0) return 2'd0;
    if (a == 2'd1) return b;
    if (b == 2'd1) return a;
    if (a == 2'd2 && b == 2'd2) return 2'd3;
    if (a == 2'd3 && b == 2'd3) return 2'd2;
    return 2'd1;
  endfunction

  task automatic send0(input logic [1:0] a, input logic [1:0] b, input logic [1:0] e);
    logic [23:0] t;
    bit ok;
    t = mask_val(8'(a), 2, 2); if0.in_a = t[3:0];
    t = mask_val(8'(b), 2, 2); if0.in_b = t[3:0];
    if0.in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (if0.in_ready) begin
        exp0.push_back(8'(e));
        ok = 1'b1;
      end else begin
        stalls0++;
      end
      @(posedge clk); #1;
    end
    if0.in_valid = 1'b0;
    if (!ok) chk("accept0", 32'(if0.in_ready), 32'd1);
  endtask

  task automatic send2(input logic [7:0] a, input logic [7:0] b, input logic [7:0] e);
    logic [23:0] t;
    bit ok;
    t = mask_val(a, 8, 3); if2.in_a = t;
    t = mask_val(b, 8, 3); if2.in_b = t;
    if2.in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (if2.in_ready) begin
        exp2.push_back(e);
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    if2.in_valid = 1'b0;
    if (!ok) chk("accept2", 32'(if2.in_ready), 32'd1);
  endtask

  // Fresh randomness every cycle for all instances.
  initial begin
    forever begin
      for (int i = 0; i < $bits(if0.rnd); i++) if0.rnd[i] = 1'($urandom_range(0, 1));
      for (int i = 0; i < $bits(if1.rnd); i++) if1.rnd[i] = 1'($urandom_range(0, 1));
      for (int i = 0; i < $bits(if2.rnd); i++) if2.rnd[i] = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  end

  // Monitor for instance 0: order, value and stability under stall.
  initial begin
    logic       held_v;
    logic [3:0] held_c;
    logic [7:0] e;
    held_v = 1'b0;
    held_c = '0;
    forever begin
      @(negedge clk);
      if (held_v && if0.out_valid) chk("hold0", 32'(if0.out_c), 32'(held_c));
      if (if0.out_valid && fire0) begin
        if (exp0.size() == 0) chk("extra0", 32'(if0.out_valid), 32'd0);
        else begin
          e = exp0.pop_front();
          chk("res0", 32'(unmask(24'(if0.out_c), 2, 2)), 32'(e));
        end
      end
      held_v = if0.out_valid && !fire0;
      held_c = if0.out_c;
    end
  end

  // Monitors for instances 1 and 2 (always ready, always fresh randomness).
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (if1.out_valid) begin
        if (exp1.size() == 0) chk("extra1", 32'(if1.out_valid), 32'd0);
        else begin
          e = exp1.pop_front();
          chk("res1", 32'(unmask(24'(if1.out_c), 4, 2)), 32'(e));
        end
      end
      if (if2.out_valid) begin
        if (exp2.size() == 0) chk("extra2", 32'(if2.out_valid), 32'd0);
        else begin
          e = exp2.pop_front();
          chk("res2", 32'(unmask(if2.out_c, 8, 3)), 32'(e));
        end
      end
    end
  end

  initial begin
    logic [23:0] t;
    logic [1:0]  ra, rb;
    if0.in_valid = 1'b0; if0.in_a = '0; if0.in_b = '0; if0.rnd_valid = 1'b1; if0.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.in_a = '0; if1.in_b = '0; if1.rnd_valid = 1'b1; if1.out_ready = 1'b1;
    if2.in_valid = 1'b0; if2.in_a = '0; if2.in_b = '0; if2.rnd_valid = 1'b1; if2.out_ready = 1'b1;
`ifdef MSK_GFMUL_FLUSH_EN
    if0.flush = 1'b0; if1.flush = 1'b0; if2.flush = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_ov0", 32'(if0.out_valid), 32'd0);
    chk("rst_ov1", 32'(if1.out_valid), 32'd0);
    chk("rst_ov2", 32'(if2.out_valid), 32'd0);
    chk("rst_rdy0", 32'(if0.in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // GF(16): 0x7 * 0x9 = 0xA, result visible after two edges.
    t = mask_val(8'h7, 4, 2); if1.in_a = t[7:0];
    t = mask_val(8'h9, 4, 2); if1.in_b = t[7:0];
    if1.in_valid = 1'b1;
    @(negedge clk);
    chk("rdy1", 32'(if1.in_ready), 32'd1);
    exp1.push_back(8'hA);
    @(posedge clk); #1;
    if1.in_valid = 1'b0;
    @(negedge clk);
    chk("lat1_early", 32'(if1.out_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat1", 32'(if1.out_valid), 32'd1);
    @(posedge clk); #1;

    // GF(256), D=3: AES products.
    send2(8'h57, 8'h83, 8'hC1);
    send2(8'h00, 8'hFF, 8'h00);

    // GF(4) directed vectors.
    send0(2'd2, 2'd2, 2'd3);
    send0(2'd2, 2'd3, 2'd1);
    send0(2'd3, 2'd3, 2'd2);
    send0(2'd1, 2'd3, 2'd3);
    send0(2'd0, 2'd3, 2'd0);

    // Back-to-back random stream: no input may ever wait.
    stalls0 = 0;
    for (int n = 0; n < 1000; n++) begin
      ra = 2'($urandom_range(0, 3));
      rb = 2'($urandom_range(0, 3));
      send0(ra, rb, gf4_mul(ra, rb));
    end
    chk("tput0", 32'(stalls0), 32'd0);

    // Randomness starvation then backpressure, with an input pending.
    send0(2'd3, 2'd1, 2'd3);
    send0(2'd2, 2'd1, 2'd2);
    t = mask_val(8'h3, 2, 2); if0.in_a = t[3:0];
    t = mask_val(8'h2, 2, 2); if0.in_b = t[3:0];
    if0.in_valid = 1'b1;
    if0.rnd_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_rnd", 32'(if0.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    if0.rnd_valid = 1'b1;
    if0.out_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("stall_bp", 32'(if0.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    if0.out_ready = 1'b1;
    send0(2'd3, 2'd2, 2'd1);
    send0(2'd1, 2'd1, 2'd1);
    repeat (4) begin @(posedge clk); #1; end

    // Reset with both stages full; held results are dropped.
    send0(2'd2, 2'd2, 2'd3);
    send0(2'd3, 2'd3, 2'd2);
    if0.out_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    if0.out_ready = 1'b1;
    exp0.delete();
    @(negedge clk);
    chk("rst_mid", 32'(if0.out_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid2", 32'(if0.out_valid), 32'd0);
    @(posedge clk); #1;
    send0(2'd3, 2'd2, 2'd1);
    @(negedge clk);
    chk("rst_lat_early", 32'(if0.out_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_lat", 32'(if0.out_valid), 32'd1);
    @(posedge clk); #1;

`ifdef MSK_GFMUL_FLUSH_EN
    // Flush with input offered: nothing accepted, pipe empties.
    send0(2'd2, 2'd3, 2'd1);
    send0(2'd3, 2'd1, 2'd3);
    t = mask_val(8'h2, 2, 2); if0.in_a = t[3:0];
    t = mask_val(8'h2, 2, 2); if0.in_b = t[3:0];
    if0.in_valid = 1'b1;
    if0.flush = 1'b1;
    @(negedge clk);
    chk("flush_rdy", 32'(if0.in_ready), 32'd0);
    @(posedge clk); #1;
    if0.flush = 1'b0;
    if0.in_valid = 1'b0;
    exp0.delete();
    @(negedge clk);
    chk("flush_ov", 32'(if0.out_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("flush_ov2", 32'(if0.out_valid), 32'd0);
    @(posedge clk); #1;
    send0(2'd2, 2'd2, 2'd3);
    send0(2'd3, 2'd3, 2'd2);
`endif

    // Drain all scoreboards within a bounded number of cycles.
    for (int n = 0; n < 20 && (exp0.size() + exp1.size() + exp2.size()) != 0; n++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("drain", 32'(exp0.size() + exp1.size() + exp2.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/msk_gfmul_hpc1_pipe.md
# msk_gfmul_hpc1_pipe

Masked multiplier over GF(2^W) in polynomial basis, built as HPC1: an SNI refresh of operand b followed by a DOM multiplication of all W×W bit pairs, then linear reduction modulo a parametrised field polynomial. It generalises the fixed GF(4) HPC1 multiplier in several ways:

- Field width is a parameter.
- Both operands arrive in the same cycle; operand a is aligned internally.
- Flow control uses valid/ready.
- The pipeline stalls when fresh randomness is unavailable.

It sits in S-box and inversion datapaths of masked cipher cores.

## Interface
- D, 2, number of shares (≥2).
- W, 2, field element width in bits (2..8).
- POLY, 2'b11, low W bits of the monic reduction polynomial (GF(4): x²+x+1).
- Derived constants:
  - R_REF = W·D(D−1)/2
  - R_MUL = W·W·D(D−1)/2
  - R = R_REF+R_MUL

Ports (bit i of a sharing, share j, is at index i·D+j):
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_a  in  W·D  sharing of operand a.
- in_b  in  W·D  sharing of operand b.
- in_valid  in  1  operands present.
- in_ready  out  1  operands accepted this cycle when in_valid=1.
- rnd  in  R  fresh randomness: [R_REF-1:0] is refresh, upper bits are DOM.
- rnd_valid  in  1  rnd is fresh this cycle.
- out_c  out  W·D  sharing of a·b mod POLY.
- out_valid  out  1  out_c holds a result.
- out_ready  in  1  downstream accepts out_c.

## Operation
- Global advance enable: en = rnd_valid & (~out_valid | out_ready). in_ready = en.
- Stage 1 (captures when en):
  - Register a into a1.
  - Register refreshed b into b1. Per bit, pairwise ISW refresh: share j ^= r_jk, share k ^= r_jk for each j<k, using the refresh slice.
  - v1 <= in_valid.
- Stage 2 (captures when en):
  - For each bit pair (i,k), DOM AND of a1[i] and b1[k].
  - Inner-domain terms are registered unmasked.
  - Cross-domain terms j≠l: a1[i][j]·b1[k][l] ^ r, with one r per unordered share pair, added to both sides. Each term is registered separately; there is no XOR before the register.
  - v2 <= v1.
- Output (combinational from stage-2 registers): per share, XOR the registered terms of each pair into the 2W−1 product coefficients, then reduce modulo POLY. Reduction is linear and applied per share.
- en=1 consumes rnd whole, even when the pipeline holds bubbles. When en=0, rnd is ignored and all registers hold.
- out_valid = v2.
- Data registers have no reset. Only v1 and v2 reset.
- D=2, W=2, POLY=2'b11 reproduces the GF(4) HPC1 function, with operand a's one-cycle skew absorbed internally.

## Timing
- Reset (rst_n=0 at an edge): v1=v2=0 at the next cycle, so out_valid=0. in_ready reflects rnd_valid during and after reset. Reset mid-stream drops in-flight results. out_c is undefined while out_valid=0.
- Latency: operands accepted at edge t give out_valid=1 after edge t+1, provided en=1 at both edges. Every cycle with en=0 adds one cycle.
- Throughput: one result per cycle while rnd_valid=1 and out_ready=1.
- Backpressure: when out_valid=1 and out_ready=0, the whole pipeline freezes and out_c stays stable. An accepted result and a new capture happen on the same edge.
- When rnd_valid=0, in_ready=0 and everything freezes, even if downstream is ready.

## Configuration
- MSK_GFMUL_FLUSH_EN:
  - Defined: adds input flush (1 bit). When flush=1 at an edge, v1 and v2 are cleared regardless of en, and no input is accepted that cycle (in_ready forced 0). Randomness is not consumed.
  - Undefined: no flush port. Behaviour as above.

## Test plan
- W=4, POLY=4'h3, D=2:
  - Inputs: a=0x7 and b=0x9, each split with random masks; rnd_valid=1 and out_ready=1 throughout.
  - Required: out_valid after 2 edges, and out_c shares XOR to 0xA.
- W=8, POLY=8'h1B, D=3:
  - Inputs: a=0x57, b=0x83.
  - Required: shares XOR to 0xC1.
  - Repeat with 0x00·0xFF, which must give 0x00.
- Default parameters, 1000 random back-to-back inputs with random masks and rnd:
  - Required: one result per cycle, each unmasking to the GF(4) product, in order.
- Randomness and backpressure:
  - Deassert rnd_valid for 3 cycles, then out_ready for 2 cycles, mid-stream.
  - Required: in_ready=0 throughout; out_c stable while out_valid=1 and out_ready=0; no results lost or duplicated.
- Reset mid-stream:
  - Stimulus: rst_n=0 for one edge with v1=v2=1.
  - Required: out_valid=0 the next cycle; first new input yields a result 2 edges later.
- With MSK_GFMUL_FLUSH_EN:
  - Stimulus: flush=1 while in_valid=1.
  - Required: in_ready=0, the pipeline empties, and the next rnd word is not skipped.
